// File: rtl/cw305_pmul_pkg.sv
// Shared types and sizing for the CW305 point-multiplication sequencer.
package cw305_pmul_pkg;

  localparam int unsigned PMUL_WORDS   = 8;
  localparam int unsigned PMUL_WORD_W  = 32;
  localparam int unsigned PMUL_OP_W    = PMUL_WORDS * PMUL_WORD_W;
  localparam int unsigned PMUL_WADDR_W = 3;
  localparam int unsigned PMUL_CNT_W   = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_LAUNCH = 3'd2,
    ST_WAIT   = 3'd3,
    ST_STORE  = 3'd4,
    ST_DONE   = 3'd5
  } pmul_state_e;

endpackage

// File: rtl/cw305_pmul_seq.sv
// Crypto-clock sequencer: fetch k/gx/gy word-wise, launch the core, write rx/ry back.
module cw305_pmul_seq
  import cw305_pmul_pkg::*;
#(
  parameter int unsigned pWORDS       = PMUL_WORDS,
  parameter int unsigned pWORD_WIDTH  = PMUL_WORD_W,
  parameter int unsigned pWADDR_WIDTH = PMUL_WADDR_W
) (
  input  logic                            crypto_clk,
  input  logic                            reset_n,
  input  logic                            start_i,
  output logic [pWADDR_WIDTH-1:0]         k_addr,
  input  logic [pWORD_WIDTH-1:0]          k_word_i,
  output logic [pWADDR_WIDTH-1:0]         gx_addr,
  output logic [pWADDR_WIDTH-1:0]         gy_addr,
  input  logic [pWORD_WIDTH-1:0]          gx_word_i,
  input  logic [pWORD_WIDTH-1:0]          gy_word_i,
  output logic [pWORDS*pWORD_WIDTH-1:0]   core_k,
  output logic [pWORDS*pWORD_WIDTH-1:0]   core_gx,
  output logic [pWORDS*pWORD_WIDTH-1:0]   core_gy,
  output logic                            core_start,
  input  logic                            core_done,
  input  logic [pWORDS*pWORD_WIDTH-1:0]   core_rx,
  input  logic [pWORDS*pWORD_WIDTH-1:0]   core_ry,
  output logic [pWADDR_WIDTH-1:0]         rx_addr,
  output logic [pWADDR_WIDTH-1:0]         ry_addr,
  output logic                            rx_wren,
  output logic                            ry_wren,
  output logic [pWORD_WIDTH-1:0]          rx_word,
  output logic [pWORD_WIDTH-1:0]          ry_word,
  output logic                            ready_o,
  output logic                            busy_o,
  output logic                            done_o
);

  localparam logic [PMUL_CNT_W-1:0]   CNT_LOAD_END  = PMUL_CNT_W'(pWORDS);
  localparam logic [PMUL_CNT_W-1:0]   CNT_STORE_END = PMUL_CNT_W'(pWORDS - 1);
  localparam logic [pWADDR_WIDTH-1:0] ADDR_LAST     = pWADDR_WIDTH'(pWORDS - 1);

  pmul_state_e               state_q, state_d;
  logic [PMUL_CNT_W-1:0]     cnt_q, cnt_d;
  logic [pWADDR_WIDTH-1:0]   cnt_addr;
  logic [pWADDR_WIDTH-1:0]   gidx;
  logic [pWADDR_WIDTH-1:0]   op_addr;
  logic [pWADDR_WIDTH-1:0]   res_addr;

  logic [pWORD_WIDTH-1:0]    k_q  [pWORDS];
  logic [pWORD_WIDTH-1:0]    gx_q [pWORDS];
  logic [pWORD_WIDTH-1:0]    gy_q [pWORDS];
  logic [pWORD_WIDTH-1:0]    rx_q [pWORDS];
  logic [pWORD_WIDTH-1:0]    ry_q [pWORDS];

  // Word index of the counter; gx/gy arrive one cycle late so they use cnt-1 (wraps 8 -> 7).
  assign cnt_addr = cnt_q[pWADDR_WIDTH-1:0];
  assign gidx     = cnt_addr - pWADDR_WIDTH'(1);

  // State and shared word counter.
  always_ff @(posedge crypto_clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and state/counter-decoded outputs.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ready_o    = 1'b0;
    busy_o     = 1'b1;
    done_o     = 1'b0;
    core_start = 1'b0;
    op_addr    = '0;
    res_addr   = '0;
    rx_wren    = 1'b0;
    ry_wren    = 1'b0;
    rx_word    = '0;
    ry_word    = '0;
    unique case (state_q)
      ST_IDLE: begin
        ready_o = 1'b1;
        busy_o  = 1'b0;
        if (start_i) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
        end
      end
      ST_LOAD: begin
        op_addr = (cnt_q < CNT_LOAD_END) ? cnt_addr : ADDR_LAST;
        cnt_d   = cnt_q + PMUL_CNT_W'(1);
        if (cnt_q == CNT_LOAD_END) state_d = ST_LAUNCH;
      end
      ST_LAUNCH: begin
        core_start = 1'b1;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        if (core_done) begin
          state_d = ST_STORE;
          cnt_d   = '0;
        end
      end
      ST_STORE: begin
        rx_wren  = 1'b1;
        ry_wren  = 1'b1;
        res_addr = cnt_addr;
        rx_word  = rx_q[cnt_addr];
        ry_word  = ry_q[cnt_addr];
        cnt_d    = cnt_q + PMUL_CNT_W'(1);
        if (cnt_q == CNT_STORE_END) state_d = ST_DONE;
      end
      ST_DONE: begin
        done_o  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign k_addr  = op_addr;
  assign gx_addr = op_addr;
  assign gy_addr = op_addr;
  assign rx_addr = res_addr;
  assign ry_addr = res_addr;

  // Operand capture during LOAD and result capture on the first core_done in WAIT.
  always_ff @(posedge crypto_clk) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(pWORDS); i++) begin
        k_q[i]  <= '0;
        gx_q[i] <= '0;
        gy_q[i] <= '0;
        rx_q[i] <= '0;
        ry_q[i] <= '0;
      end
    end else begin
      if (state_q == ST_LOAD) begin
        if (cnt_q < CNT_LOAD_END) k_q[cnt_addr] <= k_word_i;
        if (cnt_q != '0) begin
          gx_q[gidx] <= gx_word_i;
          gy_q[gidx] <= gy_word_i;
        end
      end
      if (state_q == ST_WAIT && core_done) begin
        for (int i = 0; i < int'(pWORDS); i++) begin
          rx_q[i] <= core_rx[i*pWORD_WIDTH +: pWORD_WIDTH];
          ry_q[i] <= core_ry[i*pWORD_WIDTH +: pWORD_WIDTH];
        end
      end
    end
  end

  // Flatten operand words onto the core buses.
  for (genvar gi = 0; gi < int'(pWORDS); gi++) begin : g_flat
    assign core_k [gi*pWORD_WIDTH +: pWORD_WIDTH] = k_q[gi];
    assign core_gx[gi*pWORD_WIDTH +: pWORD_WIDTH] = gx_q[gi];
    assign core_gy[gi*pWORD_WIDTH +: pWORD_WIDTH] = gy_q[gi];
  end

endmodule

// File: tb/tb_cw305_pmul_seq.sv
// Scoreboard bench for cw305_pmul_seq: register-block and core models, queued result checks.
module tb_cw305_pmul_seq;

  logic         crypto_clk = 1'b0;
  logic         reset_n;
  logic         start_i;
  logic [2:0]   k_addr, gx_addr, gy_addr, rx_addr, ry_addr;
  logic [31:0]  k_word_i, gx_word_i, gy_word_i, rx_word, ry_word;
  logic [255:0] core_k, core_gx, core_gy, core_rx, core_ry;
  logic         core_start, core_done, rx_wren, ry_wren, ready_o, busy_o, done_o;

  typedef struct {
    logic [2:0]  addr;
    logic [31:0] rx;
    logic [31:0] ry;
  } sb_t;

  sb_t exp_q[$];
  int  n_chk = 0;
  int  n_pass = 0;
  int  n_launch = 0;
  int  exp_launch = 0;
  int  gen = 0;

  cw305_pmul_seq dut (
    .crypto_clk (crypto_clk),
    .reset_n    (reset_n),
    .start_i    (start_i),
    .k_addr     (k_addr),
    .k_word_i   (k_word_i),
    .gx_addr    (gx_addr),
    .gy_addr    (gy_addr),
    .gx_word_i  (gx_word_i),
    .gy_word_i  (gy_word_i),
    .core_k     (core_k),
    .core_gx    (core_gx),
    .core_gy    (core_gy),
    .core_start (core_start),
    .core_done  (core_done),
    .core_rx    (core_rx),
    .core_ry    (core_ry),
    .rx_addr    (rx_addr),
    .ry_addr    (ry_addr),
    .rx_wren    (rx_wren),
    .ry_wren    (ry_wren),
    .rx_word    (rx_word),
    .ry_word    (ry_word),
    .ready_o    (ready_o),
    .busy_o     (busy_o),
    .done_o     (done_o)
  );

  always #5 crypto_clk = ~crypto_clk;

  function automatic logic [31:0] op_word(input logic [31:0] base, input int g, input int i);
    return base + 32'(i) + (32'(g) << 16);
  endfunction

  function automatic logic [255:0] res_x(input int g);
    return {4{64'h0123_4567_89AB_CDEF}} ^ {8{32'(g)}};
  endfunction

  function automatic logic [255:0] res_y(input int g);
    return {4{64'hFEDC_BA98_7654_3210}} ^ {8{(32'(g) << 4)}};
  endfunction

  // Register-block model: k combinational, gx/gy registered.
  assign k_word_i = op_word(32'h1000_0000, gen, int'(k_addr));
  always @(posedge crypto_clk) begin
    gx_word_i <= op_word(32'h2000_0000, gen, int'(gx_addr));
    gy_word_i <= op_word(32'h3000_0000, gen, int'(gy_addr));
  end

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic chk_reset_state(input string t);
    chk({t, "_ready"}, 256'(ready_o), 256'(1));
    chk({t, "_busy"},  256'(busy_o), 256'(0));
    chk({t, "_strb"},  256'({done_o, core_start, rx_wren, ry_wren}), 256'(0));
    chk({t, "_addr"},  256'({k_addr, gx_addr, gy_addr, rx_addr, ry_addr}), 256'(0));
    chk({t, "_words"}, 256'({rx_word, ry_word}), 256'(0));
    chk({t, "_k"},     core_k, 256'(0));
    chk({t, "_gx"},    core_gx, 256'(0));
    chk({t, "_gy"},    core_gy, 256'(0));
  endtask

  // Result write monitor: pop the scoreboard on every write-enable cycle.
  always @(negedge crypto_clk) begin
    if (rx_wren || ry_wren) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_write", 256'(1), 256'(0));
      end else begin
        sb_t e;
        e = exp_q.pop_front();
        chk("wren_pair", 256'({rx_wren, ry_wren}), 256'(2'b11));
        chk("rx_addr", 256'(rx_addr), 256'(e.addr));
        chk("ry_addr", 256'(ry_addr), 256'(e.addr));
        chk("rx_word", 256'(rx_word), 256'(e.rx));
        chk("ry_word", 256'(ry_word), 256'(e.ry));
      end
    end
    if (core_start) n_launch++;
  end

  // One full transaction; called at a negedge, returns at a negedge.
  task automatic do_run(input int g, input int lat, input int dlen, input bit poke,
                        input int rst_m, input int tail);
    logic [255:0] ek, egx, egy, rx, ry;
    gen = g;
    for (int i = 0; i < 8; i++) begin
      ek [i*32 +: 32] = op_word(32'h1000_0000, g, i);
      egx[i*32 +: 32] = op_word(32'h2000_0000, g, i);
      egy[i*32 +: 32] = op_word(32'h3000_0000, g, i);
    end
    rx = res_x(g);
    ry = res_y(g);
    for (int i = 0; i < 8; i++) exp_q.push_back('{addr: 3'(i), rx: rx[i*32 +: 32], ry: ry[i*32 +: 32]});
    exp_launch++;

    start_i = 1'b1;
    @(posedge crypto_clk);
    @(negedge crypto_clk);
    start_i = 1'b0;
    chk("busy_rise", 256'(busy_o), 256'(1));
    chk("ready_fall", 256'(ready_o), 256'(0));
    for (int n = 1; n <= 11; n++) begin
      if (n > 1) @(negedge crypto_clk);
      start_i = poke && (n == 3 || n == 11);
      chk("core_start", 256'(core_start), 256'(n == 10));
      if (n <= 9) chk("k_addr", 256'(k_addr), 256'((n <= 8) ? n - 1 : 7));
      if (n == 10) begin
        chk("core_k_top",  256'(core_k[255:224]), 256'(op_word(32'h1000_0000, g, 7)));
        chk("core_gx_bot", 256'(core_gx[31:0]),   256'(op_word(32'h2000_0000, g, 0)));
        chk("core_gy_top", 256'(core_gy[255:224]), 256'(op_word(32'h3000_0000, g, 7)));
        chk("core_k",  core_k,  ek);
        chk("core_gx", core_gx, egx);
        chk("core_gy", core_gy, egy);
      end
    end
    for (int w = 11; w < 10 + lat; w++) begin
      @(negedge crypto_clk);
      start_i = 1'b0;
    end
    core_done = 1'b1;
    core_rx   = rx;
    core_ry   = ry;
    for (int m = 1; m <= tail; m++) begin
      @(negedge crypto_clk);
      if (m == dlen) core_done = 1'b0;
      if (rst_m != 0 && m == rst_m) reset_n = 1'b0;
      if (rst_m != 0 && m == rst_m + 1) begin
        reset_n   = 1'b1;
        core_done = 1'b0;
        chk_reset_state("mid_store_rst");
        exp_q.delete();
        break;
      end
      start_i = poke && (m == 9);
      chk("store_wren", 256'(rx_wren), 256'(m <= 8));
      chk("done_o", 256'(done_o), 256'(m == 9));
      chk("ready_o", 256'(ready_o), 256'(m >= 10));
      chk("busy_o", 256'(busy_o), 256'(m < 10));
    end
    start_i = 1'b0;
    chk("sb_drain", 256'(exp_q.size()), 256'(0));
    chk("launch_count", 256'(n_launch), 256'(exp_launch));
  endtask

  initial begin
    reset_n   = 1'b0;
    start_i   = 1'b0;
    core_done = 1'b0;
    core_rx   = '0;
    core_ry   = '0;
    repeat (3) @(posedge crypto_clk);
    @(negedge crypto_clk);
    chk_reset_state("reset");

    // Start coinciding with reset must be swallowed.
    start_i = 1'b1;
    @(posedge crypto_clk);
    @(negedge crypto_clk);
    start_i = 1'b0;
    chk_reset_state("rst_vs_start");
    reset_n = 1'b1;
    @(negedge crypto_clk);
    chk("idle_after_rst", 256'({ready_o, busy_o}), 256'(2'b10));

    do_run(0, 50, 1,  1'b0, 0, 11);   // nominal pulse-mode run
    do_run(1, 20, 20, 1'b0, 0, 20);   // core_done held as a level
    do_run(2, 30, 1,  1'b1, 0, 11);   // start pokes in LOAD, WAIT, DONE
    do_run(3, 10, 1,  1'b0, 4, 12);   // reset mid-STORE at cnt=3
    do_run(4, 12, 1,  1'b0, 0, 11);   // recovery after reset
    do_run(5, 15, 1,  1'b0, 0, 10);   // back-to-back: restart in first IDLE cycle
    do_run(6, 15, 1,  1'b0, 0, 11);

    repeat (3) @(negedge crypto_clk);
    chk("final_launch_count", 256'(n_launch), 256'(exp_launch));
    chk("final_idle", 256'({ready_o, busy_o, rx_wren}), 256'(3'b100));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
